// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StPressed,
        StRelease
    } state_e;

    localparam logic [3:0] KEY_P1_END = 4'b0011;
    localparam logic [3:0] KEY_P2_END = 4'b0001;

    localparam int unsigned SCAN_DIV_DEF     = 1000;
    localparam int unsigned DEBOUNCE_CNT_DEF = 20;
    localparam int unsigned REPEAT_CNT_DEF   = 50000;

    // Index of the lowest-numbered low (pressed) column; 3 if none is low.
    function automatic logic [1:0] first_low(input logic [3:0] col);
        first_low = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!col[i]) first_low = 2'(i);
        end
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Counts consecutive samples equal to a target level; pulses stable on the Nth one.
// Shared between press (level 0) and release (level 1) qualification.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sample,
    input  logic level,
    input  logic restart,
    output logic stable
);

    localparam int unsigned CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign stable = !restart && (sample == level) && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (sample != level) || stable) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce and one-shot key events.
// Define KEYPAD_REPEAT_EN to re-pulse key_valid every REPEAT_CNT cycles while held.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = SCAN_DIV_DEF,
    parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int unsigned REPEAT_CNT   = REPEAT_CNT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 2) begin : g_bad_param
        $error("keypad_scan: parameter out of legal range");
    end

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    state_e        state_q;
    logic [3:0]    col_meta_q, col_sync_q;
    logic [DW-1:0] div_q;
    logic [1:0]    row_idx_q, col_idx_q;
    logic [3:0]    key_code_q;
    logic          key_valid_q, key_held_q;
    logic          col_bit, db_restart, db_level, db_stable;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CNT);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CNT - 1);
    logic [RW-1:0] rep_q;
`endif

    assign col_bit    = col_sync_q[col_idx_q];
    assign db_restart = (state_q == StScan) || (state_q == StPressed);
    assign db_level   = (state_q == StRelease);

    keypad_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .sample (col_bit),
        .level  (db_level),
        .restart(db_restart),
        .stable (db_stable)
    );

    // Synchronizer resets to the idle (all released) level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
        end else begin
            col_meta_q <= col_in;
            col_sync_q <= col_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StScan;
            div_q       <= '0;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                StScan: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (col_sync_q != 4'hF) begin
                            col_idx_q <= first_low(col_sync_q);
                            state_q   <= StDebounce;
                        end else begin
                            row_idx_q <= row_idx_q + 2'd1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                StDebounce: begin
                    if (col_bit) begin
                        state_q   <= StScan;
                        row_idx_q <= row_idx_q + 2'd1;
                    end else if (db_stable) begin
                        state_q     <= StPressed;
                        key_code_q  <= {row_idx_q, col_idx_q};
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        rep_q       <= '0;
`endif
                    end
                end
                StPressed: begin
                    if (col_bit) begin
                        state_q <= StRelease;
`ifdef KEYPAD_REPEAT_EN
                    end else if (rep_q == REP_LAST) begin
                        key_valid_q <= 1'b1;
                        rep_q       <= '0;
                    end else begin
                        rep_q <= rep_q + 1'b1;
`endif
                    end
                end
                StRelease: begin
                    if (!col_bit) begin
                        state_q <= StPressed;
`ifdef KEYPAD_REPEAT_EN
                        rep_q   <= '0;
`endif
                    end else if (db_stable) begin
                        state_q    <= StScan;
                        key_held_q <= 1'b0;
                        row_idx_q  <= row_idx_q + 2'd1;
                    end
                end
                default: state_q <= StScan;
            endcase
        end
    end

    assign row_out   = ~(4'b0001 << row_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_CNT=10).
// Define KEYPAD_REPEAT_EN for both RTL and bench to exercise auto-repeat.
module tb_keypad_scan;

    typedef struct {
        int         row;
        logic [3:0] mask;
        logic [3:0] code;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] col_in;
    logic [3:0] row_out, key_code;
    logic       key_valid, key_held;

    logic [3:0] keys [4];
    logic [3:0] direct_col = 4'hF;
    bit         use_model = 1'b0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit prev_v = 1'b0;
    bit double_seen = 1'b0;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV    (4),
        .DEBOUNCE_CNT(3),
        .REPEAT_CNT  (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .col_in   (col_in),
        .row_out  (row_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Matrix model: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col_in = direct_col;
        if (use_model) begin
            col_in = 4'hF;
            for (int r = 0; r < 4; r++) begin
                if (!row_out[r]) col_in = col_in & ~keys[r];
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid) pulses = pulses + 1;
        if (key_valid && prev_v) double_seen = 1'b1;
        prev_v = key_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (key_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_unheld(output int lat);
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (!key_held) begin
                lat = i;
                break;
            end
        end
    endtask

    vec_t       vecs [6];
    logic [3:0] exp_row;
    bit         ok;
    bit         held_ok;
    int         base, lat, nrep, first_pos, last_pos;

    initial begin
        vecs[0] = '{row: 0, mask: 4'b1000, code: 4'b0011};
        vecs[1] = '{row: 2, mask: 4'b0101, code: 4'b1000};
        vecs[2] = '{row: 3, mask: 4'b0001, code: 4'b1100};
        vecs[3] = '{row: 1, mask: 4'b0010, code: 4'b0101};
        vecs[4] = '{row: 0, mask: 4'b0001, code: 4'b0000};
        vecs[5] = '{row: 3, mask: 4'b1000, code: 4'b1111};
        for (int r = 0; r < 4; r++) keys[r] = 4'h0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_row", 32'(row_out), 32'(4'b1110));
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);

        // Idle scan: each row for 4 cycles, wrapping
        base = pulses;
        rst = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(negedge clk);
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            check("idle_row", 32'(row_out), 32'(exp_row));
        end
        check("idle_no_valid", 32'(pulses - base), 32'd0);

        // One-cycle low glitch on col 1: debounce aborts, scan resumes on row 1
        do_reset();
        base = pulses;
        @(negedge clk);
        direct_col = 4'b1101;
        @(negedge clk);
        direct_col = 4'hF;
        repeat (3) @(negedge clk);
        check("glitch_row1", 32'(row_out), 32'(4'b1101));
        check("glitch_held", 32'(key_held), 32'h0);
        repeat (4) @(negedge clk);
        check("glitch_row2", 32'(row_out), 32'(4'b1011));
        check("glitch_no_valid", 32'(pulses - base), 32'd0);

        // Reset mid-DEBOUNCE aborts the event
        direct_col = 4'b0111;
        do_reset();
        base = pulses;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_row", 32'(row_out), 32'(4'b1110));
        check("abort_valid", 32'(key_valid), 32'h0);
        repeat (3) @(negedge clk);
        check("abort_no_valid", 32'(pulses - base), 32'd0);

        // Key held from reset release: accepted 7 cycles later on row 0 / col 3
        rst = 1'b1;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (key_valid && lat < 0) lat = i;
        end
        check("accept_latency", 32'(lat), 32'd7);
        check("accept_code", 32'(key_code), 32'(4'b0011));
        check("accept_held", 32'(key_held), 32'h1);
        check("accept_one_pulse", 32'(pulses - base), 32'd1);
        direct_col = 4'hF;
        wait_unheld(lat);
        check("release_latency", 32'(lat), 32'd6);
        check("release_row_adv", 32'(row_out), 32'(4'b1101));

        // Table-driven presses through the matrix model
        use_model = 1'b1;
        for (int v = 0; v < 6; v++) begin
            base = pulses;
            keys[vecs[v].row] = vecs[v].mask;
            wait_valid(60, ok);
            check("vec_accept", 32'(ok), 32'h1);
            check("vec_code", 32'(key_code), 32'(vecs[v].code));
            check("vec_held", 32'(key_held), 32'h1);
            repeat (4) @(negedge clk);
            keys[vecs[v].row] = 4'h0;
            wait_unheld(lat);
            check("vec_release", 32'(lat), 32'd6);
            check("vec_one_pulse", 32'(pulses - base), 32'd1);
            check("vec_code_hold", 32'(key_code), 32'(vecs[v].code));
            repeat (2) @(negedge clk);
        end

        // Bounce during RELEASE: no second pulse, key_held stays high
        keys[2] = 4'b0101;
        wait_valid(60, ok);
        check("bounce_accept", 32'(ok), 32'h1);
        check("bounce_code", 32'(key_code), 32'(4'b1000));
        repeat (3) @(negedge clk);
        base = pulses;
        held_ok = 1'b1;
        keys[2] = 4'h0;
        repeat (2) @(negedge clk);
        keys[2] = 4'b0101;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!key_held) held_ok = 1'b0;
        end
        check("bounce_held", 32'(held_ok), 32'h1);
        keys[2] = 4'h0;
        wait_unheld(lat);
        check("bounce_release", 32'(lat), 32'd6);
        check("bounce_no_pulse", 32'(pulses - base), 32'd0);
        repeat (2) @(negedge clk);

        // Reset during PRESSED: outputs return to reset values immediately
        keys[1] = 4'b0010;
        wait_valid(60, ok);
        check("prst_accept", 32'(ok), 32'h1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("prst_row", 32'(row_out), 32'(4'b1110));
        check("prst_code", 32'(key_code), 32'h0);
        check("prst_valid", 32'(key_valid), 32'h0);
        check("prst_held", 32'(key_held), 32'h0);
        keys[1] = 4'h0;
        @(negedge clk);
        rst = 1'b1;
        check("prst_restart_row", 32'(row_out), 32'(4'b1110));
        repeat (4) @(negedge clk);
        check("prst_next_row", 32'(row_out), 32'(4'b1101));

        // Long hold: repeat pulses every 10 cycles only when auto-repeat is built in
        keys[0] = 4'b1000;
        wait_valid(60, ok);
        check("hold_accept", 32'(ok), 32'h1);
        nrep = 0;
        first_pos = -1;
        last_pos = -1;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (key_valid) begin
                nrep++;
                if (first_pos < 0) first_pos = i;
                last_pos = i;
            end
        end
`ifdef KEYPAD_REPEAT_EN
        check("repeat_count", 32'(nrep), 32'd3);
        check("repeat_first", 32'(first_pos), 32'd10);
        check("repeat_last", 32'(last_pos), 32'd30);
`else
        check("no_repeat", 32'(nrep), 32'd0);
`endif
        check("hold_code", 32'(key_code), 32'(4'b0011));
        keys[0] = 4'h0;
        wait_unheld(lat);
        check("hold_release", 32'(lat), 32'd6);

        check("valid_never_double", 32'(double_seen), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
